// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg: width helpers and beat type shared by the AXI-Stream FIFO files
package axis_fifo_pkg;

    localparam int BEAT_DATA_W = 32;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0]   tdata;
        logic [BEAT_DATA_W/8-1:0] tkeep;
        logic                     tlast;
    } axis_beat_t;

    function automatic int keep_w(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port storage, synchronous write and asynchronous read
module axis_fifo_ram
    import axis_fifo_pkg::*;
#(
    parameter int WIDTH  = 37,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through AXI-Stream FIFO with optional store-and-forward packet mode
module axis_sync_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter bit PACKET_MODE  = 1'b0,
    parameter int AFULL_THRESH = DEPTH - 2,
    localparam int KEEP_W      = keep_w(DATA_WIDTH),
    localparam int ADDR_W      = addr_w(DEPTH)
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0]     s_axis_tkeep,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0]     m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [ADDR_W:0]       occupancy,
    output logic                  almost_full
);

    localparam int BEAT_W = DATA_WIDTH + KEEP_W + 1;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pkt_cnt_q, pkt_cnt_d;
    logic              rdy_q;
    logic              wr_en, rd_en;
    logic [BEAT_W-1:0] rd_beat;

    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign almost_full   = 32'(occupancy) >= 32'(AFULL_THRESH);
    assign s_axis_tready = rdy_q && (occupancy != FULL);
    // A full FIFO releases an incomplete packet so oversize packets cannot deadlock
    assign m_axis_tvalid = (occupancy != '0) &&
                           (!PACKET_MODE || (pkt_cnt_q != '0) || (occupancy == FULL));
    assign wr_en = s_axis_tvalid && s_axis_tready;
    assign rd_en = m_axis_tvalid && m_axis_tready;
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_beat;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (ADDR_W+1)'(wr_en);
        rd_ptr_d  = rd_ptr_q + (ADDR_W+1)'(rd_en);
        pkt_cnt_d = PACKET_MODE ? pkt_cnt_q + (ADDR_W+1)'(wr_en && s_axis_tlast)
                                - (ADDR_W+1)'(rd_en && m_axis_tlast) : '0;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            rdy_q     <= 1'b1;
        end
    end

    axis_fifo_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (s_axis_aclk),
        .we   (wr_en),
        .waddr(wr_ptr_q[ADDR_W-1:0]),
        .wdata({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .raddr(rd_ptr_q[ADDR_W-1:0]),
        .rdata(rd_beat)
    );

endmodule
